// File: rtl/rdc_window.sv
// rdc_window: per-event duration/windowed request counters with sticky irq, first-offender capture and watermarks
module rdc_window #(
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 2,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int WINDOW_WIDTH  = 16,
  localparam int N  = N_CORES * CORE_EVENTS,
  localparam int CW = N_CORES > 1 ? $clog2(N_CORES) : 1,
  localparam int EW = CORE_EVENTS > 1 ? $clog2(CORE_EVENTS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [N-1:0]               events_i,
  input  logic [N*WEIGHTS_WIDTH-1:0] events_weights_i,
  input  logic [N-1:0]               mode_i,
  input  logic [WINDOW_WIDTH-1:0]    window_len_i,
  input  logic [N-1:0]               irq_mask_i,
  input  logic [N-1:0]               irq_clear_i,
  input  logic                       watermark_clear_i,
  output logic                       interruption_rdc_o,
  output logic [N-1:0]               interruption_vector_rdc_o,
  output logic [N*WEIGHTS_WIDTH-1:0] watermark_o,
  output logic                       first_valid_o,
  output logic [CW-1:0]              first_core_o,
  output logic [EW-1:0]              first_event_o,
  output logic [1:0]                 state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TRIPPED = 2'd2} state_t;
  state_t state_q;
  logic [WINDOW_WIDTH-1:0] win_q, win_d, last;
  logic boundary;
  logic [N-1:0] hit, sticky_q, sticky_d;
  logic [CW-1:0] core_d;
  logic [EW-1:0] event_d;
  assign last = window_len_i == '0 ? '0 : window_len_i - WINDOW_WIDTH'(1);
  assign boundary = win_q >= last;
  assign win_d = !enable_i || boundary ? '0 : win_q + WINDOW_WIDTH'(1);
  // window position counter; restarts from 0 whenever disabled
  always_ff @(posedge clk_i) win_q <= rst_i ? '0 : win_d;
  for (genvar i = 0; i < N; i++) begin : g_ev
    logic [WEIGHTS_WIDTH-1:0] cnt_q, cnt_d, wm_q, wm_d, base, weight;
    assign weight = events_weights_i[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH];
    assign base = mode_i[i] && boundary ? '0 : cnt_q;
    assign cnt_d = !enable_i || (!mode_i[i] && !events_i[i]) ? '0 :
                   &base ? base : base + WEIGHTS_WIDTH'(events_i[i]);
    assign wm_d = watermark_clear_i ? '0 : enable_i && cnt_q > wm_q ? cnt_q : wm_q;
    assign hit[i] = enable_i & irq_mask_i[i] & (weight != '0) & (cnt_q >= weight);
    assign watermark_o[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] = wm_q;
    // saturating event counter and its high watermark
    always_ff @(posedge clk_i) begin
      cnt_q <= rst_i ? '0 : cnt_d;
      wm_q  <= rst_i ? '0 : wm_d;
    end
  end
  assign sticky_d = enable_i ? (sticky_q & ~irq_clear_i) | hit : '0;
  // sticky interrupt flags; a new hit overrides a coincident clear
  always_ff @(posedge clk_i) sticky_q <= rst_i ? '0 : sticky_d;
  assign interruption_vector_rdc_o = sticky_q;
  assign interruption_rdc_o = |sticky_q;
  // lowest flat index among current hits, core-major
  always_comb begin
    core_d = '0;
    event_d = '0;
    for (int j = N - 1; j >= 0; j--)
      if (hit[j]) begin
        core_d = CW'(j / CORE_EVENTS);
        event_d = EW'(j % CORE_EVENTS);
      end
  end
  // supervisor FSM with registered first-offender capture
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      state_q <= IDLE;
      first_valid_o <= 1'b0;
      first_core_o <= '0;
      first_event_o <= '0;
    end else
      case (state_q)
        IDLE: state_q <= RUN;
        RUN:
          if (|hit) begin
            state_q <= TRIPPED;
            first_valid_o <= 1'b1;
            first_core_o <= core_d;
            first_event_o <= event_d;
          end
        TRIPPED:
          if (sticky_d == '0) begin
            state_q <= RUN;
            first_valid_o <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
  end
  assign state_o = state_q;
endmodule

// File: tb/tb_rdc_window.sv
// tb_rdc_window: directed self-checking bench for rdc_window
module tb_rdc_window;
  localparam int NC = 4, NE = 2, WW = 8, LW = 16, N = NC * NE;
  logic clk = 1'b0;
  logic rst, enable, wm_clr;
  logic [N-1:0] ev, mode, mask, clr, vec;
  logic [N*WW-1:0] weights, wm;
  logic [LW-1:0] wlen;
  logic irq, fv;
  logic [1:0] fc, st;
  logic [0:0] fe;
  int checks = 0, errors = 0;
  rdc_window #(.N_CORES(NC), .CORE_EVENTS(NE), .WEIGHTS_WIDTH(WW), .WINDOW_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .events_i(ev), .events_weights_i(weights),
    .mode_i(mode), .window_len_i(wlen), .irq_mask_i(mask), .irq_clear_i(clr),
    .watermark_clear_i(wm_clr), .interruption_rdc_o(irq), .interruption_vector_rdc_o(vec),
    .watermark_o(wm), .first_valid_o(fv), .first_core_o(fc), .first_event_o(fe), .state_o(st)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [WW-1:0] wmv(input int i);
    return wm[i*WW +: WW];
  endfunction
  task automatic setw(input int i, input logic [WW-1:0] w);
    weights[i*WW +: WW] = w;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; enable = 0; wm_clr = 0; ev = '0; mode = '0; mask = '1; clr = '0;
    weights = '0; wlen = 16'd10;
    step(); step();
    rst = 0;
    check("rst_state", st, 0);
    check("rst_irq", irq, 0);
    check("rst_vec", vec, 0);
    check("rst_wm", wm, 0);
    check("rst_fv", fv, 0);
    // duration mode, W=5 on core1/event0
    setw(2, 8'd5);
    enable = 1; ev = 8'h04;
    repeat (4) step();
    ev = 8'h00;
    repeat (3) step();
    check("d4_no_irq", irq, 0);
    check("d4_wm", wmv(2), 4);
    check("d4_state_run", st, 1);
    ev = 8'h04;
    repeat (5) step();
    ev = 8'h00;
    check("d5_not_yet", vec, 0);
    step();
    check("d5_vec", vec, 8'h04);
    check("d5_irq", irq, 1);
    check("d5_state", st, 2);
    check("d5_fv", fv, 1);
    check("d5_fcore", fc, 1);
    check("d5_fevent", fe, 0);
    check("d5_wm", wmv(2), 5);
    clr = 8'h04;
    step();
    clr = 8'h00;
    check("d5_clr_vec", vec, 0);
    check("d5_clr_state", st, 1);
    check("d5_clr_fv", fv, 0);
    // simultaneous hits on [0][1] and [2][0]
    setw(2, 8'd0); setw(1, 8'd3); setw(4, 8'd3);
    ev = 8'h12;
    repeat (3) step();
    ev = 8'h00;
    step();
    check("two_vec", vec, 8'h12);
    check("two_fcore", fc, 0);
    check("two_fevent", fe, 1);
    check("two_state", st, 2);
    clr = 8'h02;
    step();
    clr = 8'h00;
    check("two_clr1_vec", vec, 8'h10);
    check("two_clr1_state", st, 2);
    check("two_clr1_fv", fv, 1);
    clr = 8'h10;
    step();
    clr = 8'h00;
    check("two_clr2_vec", vec, 0);
    check("two_clr2_state", st, 1);
    check("two_clr2_fv", fv, 0);
    // saturation at 0xFF, clear coincident with hit
    setw(1, 8'd0); setw(4, 8'd0); setw(0, 8'hFF);
    ev = 8'h01;
    repeat (300) step();
    check("sat_wm", wmv(0), 8'hFF);
    check("sat_vec", vec, 8'h01);
    check("sat_state", st, 2);
    check("sat_fcore", fc, 0);
    check("sat_fevent", fe, 0);
    clr = 8'h01;
    step();
    clr = 8'h00;
    check("clr_vs_hit", vec, 8'h01);
    wm_clr = 1;
    step();
    wm_clr = 0;
    check("wmclr_0", wmv(0), 0);
    check("wmclr_2", wmv(2), 0);
    step();
    check("sat_no_wrap", wmv(0), 8'hFF);
    // disable, then windowed mode L=10 W=4 on [1][1]
    ev = 8'h00; enable = 0;
    step();
    check("dis_vec", vec, 0);
    check("dis_state", st, 0);
    check("dis_irq", irq, 0);
    check("dis_wm_hold", wmv(0), 8'hFF);
    setw(0, 8'd0); setw(3, 8'd4); mode = 8'h08;
    enable = 1;
    for (int c = 0; c < 10; c++) begin
      ev = (c == 0 || c == 2 || c == 4 || c == 8) ? 8'h08 : 8'h00;
      if (c == 9) check("win_not_yet", vec, 0);
      step();
    end
    ev = 8'h00;
    check("win_vec", vec, 8'h08);
    check("win_state", st, 2);
    check("win_fcore", fc, 1);
    check("win_fevent", fe, 1);
    check("win_wm", wmv(3), 4);
    // straddling the boundary never hits
    enable = 0;
    step();
    enable = 1;
    for (int c = 0; c < 14; c++) begin
      ev = (c == 7 || c == 8 || c == 10 || c == 11) ? 8'h08 : 8'h00;
      step();
    end
    ev = 8'h00;
    check("straddle_vec", vec, 0);
    check("straddle_irq", irq, 0);
    // masked event with weight 0 still tracks watermark
    mask = 8'hDF; setw(5, 8'd0);
    ev = 8'h20;
    repeat (6) step();
    ev = 8'h00;
    step();
    check("mask_vec", vec, 0);
    check("mask_wm", wmv(5), 6);
    enable = 0;
    step();
    check("dis2_state", st, 0);
    check("dis2_wm_hold", wmv(5), 6);
    wm_clr = 1;
    step();
    wm_clr = 0;
    check("dis2_wmclr5", wmv(5), 0);
    check("dis2_wmclr3", wmv(3), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rdc_window.md
# rdc_window

Next-generation Request Duration Counter for the PMU/MCCU contention-enforcement path. For every monitored core event it runs a saturating counter in one of two per-event modes: consecutive-duration or windowed-accumulation. It raises a maskable, sticky interrupt when the counter reaches the programmed weight, and records the first offending core/event. It keeps a clearable high watermark per event, and sits beside the MCCU, taking the same per-core event vectors and software-set weights.

## Interface
- N_CORES, 4, monitored cores
- CORE_EVENTS, 2, events per core
- WEIGHTS_WIDTH, 8, counter, weight and watermark width
- WINDOW_WIDTH, 16, window-length register width
- clk_i  in  1  single clock, all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  active-high enable
- events_i  in  [CORE_EVENTS-1:0] x N_CORES  monitored event levels
- events_weights_i  in  [WEIGHTS_WIDTH-1:0] x N_CORES x CORE_EVENTS  threshold; 0 disables that event
- mode_i  in  [CORE_EVENTS-1:0] x N_CORES  0 = duration, 1 = windowed
- window_len_i  in  WINDOW_WIDTH  window length L in cycles; 0 treated as 1
- irq_mask_i  in  [CORE_EVENTS-1:0] x N_CORES  1 = event may interrupt
- irq_clear_i  in  [CORE_EVENTS-1:0] x N_CORES  single-cycle pulse, clears the sticky bit
- watermark_clear_i  in  1  pulse, zeroes all watermarks
- interruption_rdc_o  out  1  OR of sticky vector
- interruption_vector_rdc_o  out  [CORE_EVENTS-1:0] x N_CORES  sticky per-event flags
- watermark_o  out  [WEIGHTS_WIDTH-1:0] x N_CORES x CORE_EVENTS  max counter value seen
- first_valid_o  out  1  first-offender capture valid
- first_core_o  out  max(1,$clog2(N_CORES))  core index of first offender
- first_event_o  out  max(1,$clog2(CORE_EVENTS))  event index of first offender
- state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 TRIPPED

## Operation
- Counters cnt[c][e] are WEIGHTS_WIDTH wide and saturate at all-ones. There is no wrap.
- !enable_i: counters, sticky vector, first-offender fields and the window counter load 0. Watermarks hold.
- Mode 0 (duration):
  - event high: cnt <= sat(cnt+1)
  - event low: cnt <= 0
- Window counter win: counts 0..L-1 while enabled. On the edge where win == L-1 it wraps to 0; that edge is the window boundary.
- Mode 1 (windowed):
  - boundary edge: cnt <= event_i ? 1 : 0
  - any other edge: cnt <= sat(cnt + event_i)
- Mode changes take effect on the next edge. The counter is not cleared.
- Hit, combinational, uses the registered cnt: hit[c][e] = enable_i & irq_mask_i & (weight != 0) & (cnt >= weight).
- Sticky vector: sticky <= (sticky & ~irq_clear_i) | hit. If hit and clear coincide, set wins.
- interruption_rdc_o = |sticky (registered, no combinational path from events).
- Watermark, when enabled:
  - if cnt > wm: wm <= cnt
  - watermark_clear_i: wm <= 0, and the update is ignored that cycle
  - while disabled: wm holds; watermark_clear_i still zeroes it
- FSM:
  - IDLE: goes to RUN when enable_i.
  - RUN:
    - if any hit: capture the lowest flat index (c*CORE_EVENTS+e, core-major), set first_valid_o, go to TRIPPED.
  - TRIPPED:
    - if the next sticky vector is all-zero: clear first_valid_o, return to RUN.
    - first_* do not change while TRIPPED.
  - Any state with !enable_i goes to IDLE.

## Timing
- Reset values:
  - all counters, watermarks, sticky bits and first_* = 0
  - interruption_rdc_o = 0, first_valid_o = 0
  - state_o = IDLE, window counter = 0
- Mode 0, weight W, event high from cycle 0:
  - cnt == W during cycle W, hit in cycle W
  - sticky and interrupt visible from cycle W+1
- A pulse of W-1 cycles never hits.
- Watermark lags cnt by one cycle.
- first_* and state_o == TRIPPED are visible in the same cycle as the sticky bit.
- A clear pulse in cycle k drops the sticky bit in k+1, unless a hit occurs in k.
- Reset or disable mid-window: the window restarts at win=0 after re-enable.

## Test plan
- Mode 0, W=5, event[1][0] high 4 cycles then low: no interrupt. High 5 cycles: interruption_vector_rdc_o[1][0]=1 at cycle 6, first_core_o=1, first_event_o=0, state_o=2.
- Mode 0, W=0xFF, event held 300 cycles: cnt and watermark saturate at 0xFF; no wrap to 0.
- Mode 1, L=10, W=4, event high at cycles 0,2,4 and then 8 (boundary after cycle 9): hit in cycle 9. Four events at cycles 7,8 and 10,11 straddling the boundary: no hit.
- Events [0][1] and [2][0] hit in the same cycle: both sticky bits set, first_core_o=0, first_event_o=1. Clearing only [0][1] keeps TRIPPED; clearing [2][0] returns to RUN with first_valid_o=0.
- Clear pulse coincident with an ongoing hit: the sticky bit stays 1.
- irq_mask_i=0 with weight 0 and counter above the weight: no interrupt, but the watermark still tracks. Disable mid-run clears sticky bits and keeps watermarks; watermark_clear_i zeroes them.
